reaction_session_controller: RTL and testbench

Session sequencer for the reaction-time benchmark. It runs a fixed number of rounds: it issues `start_trigger`, supplies a pseudo-random `random_delay` from an internal LFSR, and gates the player button into `user_trigger`. It also detects false starts and times out idle rounds. It collects each round's BCD result and reports the best time and session completion to the display and top level.

---
 rtl/reaction_session_controller.sv | 160 ++++++++++++++++
 tb/tb_reaction_session_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_session_controller.sv
// Session sequencer for the reaction-time benchmark: arms rounds with an LFSR-derived
// delay, gates the player button, handles false starts/timeouts and tracks the best result.
module reaction_session_controller #(
  parameter int unsigned ROUNDS     = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] MIN_DELAY  = 16'd12500,
  parameter logic [15:0] GAP_CYCLES = 16'd25000,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_user,
  input  logic        react_in,
  input  logic        result_valid,
  input  logic [15:0] result_bcd,
  output logic        start_trigger,
  output logic        user_trigger,
  output logic [15:0] random_delay,
  output logic [3:0]  round_idx,
  output logic [15:0] best_bcd,
  output logic [3:0]  false_start_cnt,
  output logic        busy,
  output logic        session_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_REACT, S_WAIT_RESULT, S_GAP, S_DONE
  } state_t;

  localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);

  state_t      state_q, state_d;
  logic        start_q, user_q;
  logic [15:0] lfsr_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] delay_q, delay_d;
  logic [3:0]  round_q, round_d;
  logic [15:0] best_q, best_d;
  logic [3:0]  fs_q, fs_d;
  logic        start_trig_q, start_trig_d;
  logic        user_trig_q, user_trig_d;
  logic        busy_q, done_q;
  logic        start_edge, user_edge;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] sat_delay(input logic [15:0] s);
    logic [16:0] sum;
    sum = {1'b0, MIN_DELAY} + {5'b0, s[11:0]};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign start_edge = btn_start & ~start_q;
  assign user_edge  = btn_user & ~user_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    delay_d      = delay_q;
    round_d      = round_q;
    best_d       = best_q;
    fs_d         = fs_q;
    start_trig_d = 1'b0;
    user_trig_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          round_d = 4'd0;
          best_d  = 16'h9999;
          fs_d    = 4'd0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        delay_d      = sat_delay(lfsr_q);
        start_trig_d = 1'b1;
        cnt_d        = 16'd0;
        state_d      = S_WAIT_REACT;
      end
      S_WAIT_REACT: begin
        // A press always wins over a simultaneous timeout, so only one trigger is issued.
        if (user_edge) begin
          user_trig_d = 1'b1;
          if (react_in) begin
            state_d = S_WAIT_RESULT;
          end else begin
            fs_d    = (fs_q == 4'hF) ? fs_q : fs_q + 4'd1;
            cnt_d   = 16'd0;
            state_d = S_GAP;
          end
        end else if (react_in) begin
          if (cnt_q == TIMEOUT - 16'd1) begin
            user_trig_d = 1'b1;
            state_d     = S_WAIT_RESULT;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_WAIT_RESULT: begin
        if (result_valid) begin
          if (result_bcd < best_q) best_d = result_bcd;
          round_d = round_q + 4'd1;
          cnt_d   = 16'd0;
          state_d = (round_q + 4'd1 == ROUNDS_L) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_CYCLES - 16'd1) state_d = S_ARM;
        else                             cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b1;
      user_q       <= 1'b1;
      lfsr_q       <= LFSR_SEED;
      cnt_q        <= 16'd0;
      delay_q      <= MIN_DELAY;
      round_q      <= 4'd0;
      best_q       <= 16'h9999;
      fs_q         <= 4'd0;
      start_trig_q <= 1'b0;
      user_trig_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= btn_start;
      user_q       <= btn_user;
      lfsr_q       <= lfsr_step(lfsr_q);
      cnt_q        <= cnt_d;
      delay_q      <= delay_d;
      round_q      <= round_d;
      best_q       <= best_d;
      fs_q         <= fs_d;
      start_trig_q <= start_trig_d;
      user_trig_q  <= user_trig_d;
      busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign start_trigger   = start_trig_q;
  assign user_trigger    = user_trig_q;
  assign random_delay    = delay_q;
  assign round_idx       = round_q;
  assign best_bcd        = best_q;
  assign false_start_cnt = fs_q;
  assign busy            = busy_q;
  assign session_done    = done_q;

endmodule

// File: tb/tb_reaction_session_controller.sv
// Bench for reaction_session_controller: table-driven session, directed corner sequences
// and randomized sessions checked against a round-level reference model.
module tb_reaction_session_controller;

  localparam int          ROUNDS  = 3;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam logic [15:0] MIN_D   = 16'd12500;
  localparam logic [15:0] MIN_SAT = 16'hFF00;
  localparam int          GAP     = 6;
  localparam int          TMO     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start = 1'b0, btn_user = 1'b0, react_in = 1'b0, result_valid = 1'b0;
  logic [15:0] result_bcd = 16'h0;
  logic        start_trigger, user_trigger, busy, session_done;
  logic [15:0] random_delay, best_bcd;
  logic [3:0]  round_idx, false_start_cnt;
  logic        s_start_trigger, s_user_trigger, s_busy, s_session_done;
  logic [15:0] s_random_delay, s_best_bcd;
  logic [3:0]  s_round_idx, s_false_start_cnt;

  always #5 clk = ~clk;

  reaction_session_controller #(
    .ROUNDS(ROUNDS), .LFSR_SEED(SEED), .MIN_DELAY(MIN_D),
    .GAP_CYCLES(16'(GAP)), .TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_user(btn_user),
    .react_in(react_in), .result_valid(result_valid), .result_bcd(result_bcd),
    .start_trigger(start_trigger), .user_trigger(user_trigger),
    .random_delay(random_delay), .round_idx(round_idx), .best_bcd(best_bcd),
    .false_start_cnt(false_start_cnt), .busy(busy), .session_done(session_done)
  );

  reaction_session_controller #(
    .ROUNDS(ROUNDS), .LFSR_SEED(SEED), .MIN_DELAY(MIN_SAT),
    .GAP_CYCLES(16'(GAP)), .TIMEOUT(16'(TMO))
  ) dut_sat (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_user(btn_user),
    .react_in(react_in), .result_valid(result_valid), .result_bcd(result_bcd),
    .start_trigger(s_start_trigger), .user_trigger(s_user_trigger),
    .random_delay(s_random_delay), .round_idx(s_round_idx), .best_bcd(s_best_bcd),
    .false_start_cnt(s_false_start_cnt), .busy(s_busy), .session_done(s_session_done)
  );

  int n_vec = 0, n_err = 0;
  int n_arms = 0, n_user = 0, n_sat = 0;
  int cyc = 0;
  logic [15:0] m_lfsr, m_prev;
  logic        prev_start = 1'b0, prev_user = 1'b0;
  int          m_round, m_fs;
  logic [15:0] m_best;

  typedef struct {
    logic [15:0] result;
    logic [15:0] exp_best;
    logic [3:0]  exp_round;
  } vec_t;
  vec_t tbl[ROUNDS];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [15:0] exp_delay(input logic [15:0] mn, input logic [15:0] l);
    int unsigned v;
    v = int'(mn) + int'(l & 16'h0FFF);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [15:0] rand_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (!start_trigger && n < budget) begin
      tick();
      n++;
    end
    chk("start_trigger_arrives", 32'(start_trigger), 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_start_trigger", 32'(start_trigger), 32'd0);
    chk("rst_user_trigger", 32'(user_trigger), 32'd0);
    chk("rst_random_delay", 32'(random_delay), 32'(MIN_D));
    chk("rst_round_idx", 32'(round_idx), 32'd0);
    chk("rst_best_bcd", 32'(best_bcd), 32'h9999);
    chk("rst_false_start_cnt", 32'(false_start_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_session_done", 32'(session_done), 32'd0);
  endtask

  // Model of the free-running LFSR; m_prev is the value the design used at the last edge.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_prev <= m_lfsr;
    m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);
  end

  always @(negedge clk) begin
    if (start_trigger) begin
      n_arms++;
      chk("random_delay", 32'(random_delay), 32'(exp_delay(MIN_D, m_prev)));
      chk("random_delay_sat", 32'(s_random_delay), 32'(exp_delay(MIN_SAT, m_prev)));
      chk("delay_in_range", 32'((random_delay >= MIN_D) && (random_delay <= MIN_D + 16'd4095)), 32'd1);
      if (s_random_delay == 16'hFFFF) n_sat++;
      if (prev_start) chk("start_trigger_width", 32'd2, 32'd1);
    end
    if (user_trigger) begin
      n_user++;
      if (prev_user) chk("user_trigger_width", 32'd2, 32'd1);
    end
    prev_start <= start_trigger;
    prev_user  <= user_trigger;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int arms0, users0, res_cyc, k, r, d;
    tbl[0] = '{16'h0250, 16'h0250, 4'd1};
    tbl[1] = '{16'h0180, 16'h0180, 4'd2};
    tbl[2] = '{16'h0310, 16'h0180, 4'd3};

    // Reset with the start button held: no session until it is released and pressed again.
    btn_start = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_vals();
    tick(); tick(); tick();
    chk("held_btn_no_start", 32'(busy), 32'd0);
    btn_start = 1'b0;
    tick();
    arms0 = n_arms;
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_no_trigger_yet", 32'(start_trigger), 32'd0);
    tick();
    chk("start_latency", 32'(start_trigger), 32'd1);

    // Table-driven session; round 1 presses in the same cycle react_in rises.
    for (int i = 0; i < ROUNDS; i++) begin
      if (i > 0) begin
        wait_start(40);
        chk("round_spacing", 32'(cyc - (res_cyc - 1)), 32'(GAP + 2));
      end
      tick(); tick();
      if (i == 1) begin
        react_in = 1'b1; btn_user = 1'b1;
        tick();
      end else begin
        react_in = 1'b1;
        tick();
        btn_user = 1'b1;
        tick();
      end
      chk("press_user_trigger", 32'(user_trigger), 32'd1);
      chk("press_no_false_start", 32'(false_start_cnt), 32'd0);
      btn_user = 1'b0; react_in = 1'b0;
      tick();
      result_valid = 1'b1; result_bcd = tbl[i].result;
      tick();
      res_cyc = cyc;
      result_valid = 1'b0;
      chk("tbl_round_idx", 32'(round_idx), 32'(tbl[i].exp_round));
      chk("tbl_best_bcd", 32'(best_bcd), 32'(tbl[i].exp_best));
      if (i == 0) begin
        tick();
        result_valid = 1'b1; result_bcd = 16'h0001;
        tick();
        result_valid = 1'b0;
        chk("stray_result_round", 32'(round_idx), 32'd1);
        chk("stray_result_best", 32'(best_bcd), 32'h0250);
      end
    end
    chk("session_done", 32'(session_done), 32'd1);
    chk("done_not_busy", 32'(busy), 32'd0);
    tick(); tick();
    chk("three_start_pulses", 32'(n_arms - arms0), 32'd3);
    chk("done_holds_best", 32'(best_bcd), 32'h0180);

    // Timeout, then false starts up to saturation.
    btn_start = 1'b1; tick(); btn_start = 1'b0;
    chk("restart_clears_round", 32'(round_idx), 32'd0);
    chk("restart_clears_best", 32'(best_bcd), 32'h9999);
    wait_start(40);
    react_in = 1'b1;
    k = 0;
    while (!user_trigger && k < 30) begin
      tick();
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'(TMO));
    react_in = 1'b0;
    tick();
    result_valid = 1'b1; result_bcd = 16'h9999;
    tick();
    result_valid = 1'b0;
    chk("timeout_best_9999", 32'(best_bcd), 32'h9999);
    chk("timeout_round", 32'(round_idx), 32'd1);
    for (int j = 0; j < 17; j++) begin
      wait_start(40);
      tick();
      btn_user = 1'b1;
      tick();
      btn_user = 1'b0;
      chk("false_start_trigger", 32'(user_trigger), 32'd1);
      chk("false_start_cnt", 32'(false_start_cnt), 32'((j + 1 > 15) ? 15 : j + 1));
      chk("false_start_round", 32'(round_idx), 32'd1);
    end

    // Reset in the middle of WAIT_REACT.
    wait_start(40);
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_vals();
    arms0 = n_arms; users0 = n_user;
    for (int j = 0; j < 30; j++) begin
      btn_user = j[1]; react_in = j[2];
      tick();
    end
    btn_user = 1'b0; react_in = 1'b0;
    chk("post_reset_no_start", 32'(n_arms - arms0), 32'd0);
    chk("post_reset_no_user", 32'(n_user - users0), 32'd0);
    chk("post_reset_idle", 32'(busy), 32'd0);

    // Randomized sessions against the round-level model.
    for (int s = 0; s < 400 && n_arms < 1000; s++) begin
      btn_start = 1'b1; tick(); btn_start = 1'b0;
      m_round = 0; m_best = 16'h9999; m_fs = 0;
      for (int g = 0; g < 60 && m_round < ROUNDS; g++) begin
        wait_start(40);
        r = int'($urandom_range(0, 9));
        if (r < 3) begin
          for (int j = int'($urandom_range(0, 2)); j > 0; j--) tick();
          btn_user = 1'b1;
          if (r == 0) btn_start = 1'b1;
          tick();
          btn_user = 1'b0; btn_start = 1'b0;
          m_fs = (m_fs < 15) ? m_fs + 1 : 15;
          chk("rnd_fs_trigger", 32'(user_trigger), 32'd1);
          chk("rnd_fs_cnt", 32'(false_start_cnt), 32'(m_fs));
          chk("rnd_fs_round", 32'(round_idx), 32'(m_round));
        end else begin
          if (r == 3) begin
            result_valid = 1'b1; result_bcd = 16'h0000;
            tick();
            result_valid = 1'b0;
          end
          for (int j = int'($urandom_range(0, 3)); j > 0; j--) tick();
          react_in = 1'b1;
          if (r == 9) begin
            k = 0;
            while (!user_trigger && k < 30) begin
              tick();
              k++;
            end
            chk("rnd_timeout_cycles", 32'(k), 32'(TMO));
          end else begin
            d = int'($urandom_range(0, 4));
            for (int j = 0; j < d; j++) tick();
            btn_user = 1'b1;
            tick();
            btn_user = 1'b0;
            chk("rnd_press_trigger", 32'(user_trigger), 32'd1);
          end
          react_in = 1'b0;
          for (int j = int'($urandom_range(0, 3)); j > 0; j--) tick();
          result_valid = 1'b1; result_bcd = rand_bcd();
          if (result_bcd < m_best) m_best = result_bcd;
          m_round++;
          tick();
          result_valid = 1'b0;
          chk("rnd_round_idx", 32'(round_idx), 32'(m_round));
          chk("rnd_best_bcd", 32'(best_bcd), 32'(m_best));
          chk("rnd_fs_kept", 32'(false_start_cnt), 32'(m_fs));
        end
      end
      chk("rnd_session_done", 32'(session_done), 32'd1);
      tick();
    end
    chk("arm_count_reached", 32'(n_arms >= 1000), 32'd1);
    chk("saturated_delay_seen", 32'(n_sat > 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
